control_multicycle: RTL

CONTROL_MULTICYCLE -- requirements
Module: control_multicycle

---
 rtl/control_multicycle_if.sv | 39 +++
 rtl/control_multicycle.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_multicycle_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
// Valid/ready: mem_ready is the datapath's completion strobe; the controller holds its request until it is seen.
interface control_multicycle_if #(
    parameter int ALUOP_W = 5
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ready;

    logic               PCWrite;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic               ALUSrcA;
    logic               isSigned;
    logic [1:0]         RegDst;
    logic [1:0]         MemtoReg;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSource;
    logic [ALUOP_W-1:0] ALUOp;
    logic [3:0]         state;
    logic               illegal;
    logic               bus_err;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, isSigned,
        output RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp, state, illegal, bus_err
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, isSigned,
        input  RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp, state, illegal, bus_err
    );
endinterface

// File: rtl/control_multicycle.sv
// Multicycle MIPS-style control FSM with per-access memory timeout and illegal-opcode detection.
// Memory handshake: a request (MemRead/MemWrite) is held until mem_ready=1 or the wait counter expires.
module control_multicycle #(
    parameter int ALUOP_W = 5,
    parameter int TIMEOUT = 15
) (
    input logic clk,
    input logic rst_n,
    control_multicycle_if.master bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADDR = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        JR      = 4'd10
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_RTYPE = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_LUI   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;

    function automatic logic [ALUOP_W-1:0] alu_code(input logic [3:0] c);
        return ALUOP_W'(c);
    endfunction

    state_t          state_q, state_d;
    logic [5:0]      op_q, funct_q;
    logic [CW-1:0]   wait_q;

    logic [5:0]      op, fn;
    logic            is_rtype, is_jr, is_mem, is_itype, is_branch, is_jump, is_unsigned_imm;
    logic            wait_state, timeout;

    logic            pc_write, ior_d, mem_read, mem_write, ir_write, reg_write, alu_src_a, is_signed;
    logic [1:0]      reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic            illegal_c, bus_err_c;

    // The instruction register is loaded on the FETCH->DECODE edge, so the fields are only
    // valid live during DECODE; they are captured on leaving DECODE for the later states.
    assign op = (state_q == DECODE) ? bus.opcode : op_q;
    assign fn = (state_q == DECODE) ? bus.funct  : funct_q;

    always_comb begin
        is_rtype        = (op == OP_RTYPE);
        is_jr           = is_rtype && (fn == FN_JR);
        is_mem          = (op == OP_LW) || (op == OP_SW);
        is_itype        = (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_SLTIU) ||
                          (op == OP_ANDI) || (op == OP_ORI)  || (op == OP_XORI)  ||
                          (op == OP_LUI);
        is_branch       = (op == OP_BEQ) || (op == OP_BNE);
        is_jump         = (op == OP_J) || (op == OP_JAL);
        is_unsigned_imm = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
    end

    assign wait_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timeout    = wait_state && !bus.mem_ready && (wait_q == CW'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ior_d      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        is_signed  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_b  = 2'b00;
        pc_source  = 2'b00;
        alu_op     = '0;
        illegal_c  = 1'b0;
        bus_err_c  = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = alu_code(ALU_ADD);
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = DECODE;
                end else if (timeout) begin
                    bus_err_c = 1'b1;
                    state_d   = FETCH;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = alu_code(ALU_ADD);
                if (is_mem)                      state_d = MEMADDR;
                else if (is_jr)                  state_d = JR;
                else if (is_rtype || is_itype)   state_d = EXEC;
                else if (is_branch)              state_d = BRANCH;
                else if (is_jump)                state_d = JUMP;
                else begin
                    illegal_c = 1'b1;
                    state_d   = FETCH;
                end
            end
            MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = alu_code(ALU_ADD);
                state_d   = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEMWB;
                end else if (timeout) begin
                    bus_err_c = 1'b1;
                    state_d   = FETCH;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                state_d    = FETCH;
            end
            MEMWR: begin
                // The store is withdrawn in the cycle it times out.
                mem_write = !timeout;
                ior_d     = 1'b1;
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end else if (timeout) begin
                    bus_err_c = 1'b1;
                    state_d   = FETCH;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                if (is_rtype) begin
                    alu_src_b = 2'b00;
                    alu_op    = alu_code(ALU_RTYPE);
                end else begin
                    alu_src_b = 2'b10;
                    case (op)
                        OP_SLTI:  alu_op = alu_code(ALU_SLT);
                        OP_SLTIU: alu_op = alu_code(ALU_SLTU);
                        OP_ANDI:  alu_op = alu_code(ALU_AND);
                        OP_ORI:   alu_op = alu_code(ALU_OR);
                        OP_XORI:  alu_op = alu_code(ALU_XOR);
                        OP_LUI:   alu_op = alu_code(ALU_LUI);
                        default:  alu_op = alu_code(ALU_ADD);
                    endcase
                end
                is_signed = !is_unsigned_imm;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b00;
                reg_dst    = is_rtype ? 2'b01 : 2'b00;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                alu_op    = alu_code(ALU_SUB);
                pc_source = 2'b01;
                pc_write  = (op == OP_BNE) ? !bus.zero : bus.zero;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                if (op == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
                state_d = FETCH;
            end
            JR: begin
                pc_write  = 1'b1;
                pc_source = 2'b11;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            wait_q  <= '0;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q    <= bus.opcode;
                funct_q <= bus.funct;
            end
            // Zero in every non-waiting state means each wait state is entered with a clear count.
            if (wait_state && !bus.mem_ready && !timeout) wait_q <= wait_q + CW'(1);
            else                                          wait_q <= '0;
        end
    end

    // Enables and exception pulses are held off combinationally while reset is asserted.
    assign bus.PCWrite  = pc_write  && rst_n;
    assign bus.IRWrite  = ir_write  && rst_n;
    assign bus.RegWrite = reg_write && rst_n;
    assign bus.MemRead  = mem_read  && rst_n;
    assign bus.MemWrite = mem_write && rst_n;
    assign bus.illegal  = illegal_c && rst_n;
    assign bus.bus_err  = bus_err_c && rst_n;

    assign bus.IorD     = ior_d;
    assign bus.ALUSrcA  = alu_src_a;
    assign bus.isSigned = is_signed;
    assign bus.RegDst   = reg_dst;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.PCSource = pc_source;
    assign bus.ALUOp    = alu_op;
    assign bus.state    = state_q;

endmodule
